// File: rtl/exe_stage.sv
// Execute stage: holds one decoded instruction and presents the ALU result to the memory stage.
// The ALU reads only the latched operands, so the result appears one cycle after acceptance.
module alu #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_NUM     = 12
) (
  input  logic [OP_NUM-1:0]     alu_op,
  input  logic [DATA_WIDTH-1:0] alu_src1,
  input  logic [DATA_WIDTH-1:0] alu_src2,
  output logic [DATA_WIDTH-1:0] alu_result
);
  logic [DATA_WIDTH-1:0] add_res, sub_res, sll_res, srl_res, sra_res, lui_res;
  logic                  slt_bit, sltu_bit;
  logic [4:0]            shamt;

  assign shamt    = alu_src1[4:0];
  assign add_res  = alu_src1 + alu_src2;
  assign sub_res  = alu_src1 - alu_src2;
  assign slt_bit  = $signed(alu_src1) < $signed(alu_src2);
  assign sltu_bit = alu_src1 < alu_src2;
  assign sll_res  = alu_src2 << shamt;
  assign srl_res  = alu_src2 >> shamt;
  // Kept as a standalone signed expression so the shift stays arithmetic.
  assign sra_res  = $signed(alu_src2) >>> shamt;
  assign lui_res  = alu_src2 << 16;

  always_comb begin
    alu_result = '0;
    if (alu_op[0])  alu_result |= add_res;
    if (alu_op[1])  alu_result |= sub_res;
    if (alu_op[2])  alu_result |= {{(DATA_WIDTH-1){1'b0}}, slt_bit};
    if (alu_op[3])  alu_result |= {{(DATA_WIDTH-1){1'b0}}, sltu_bit};
    if (alu_op[4])  alu_result |= alu_src1 & alu_src2;
    if (alu_op[5])  alu_result |= ~(alu_src1 | alu_src2);
    if (alu_op[6])  alu_result |= alu_src1 | alu_src2;
    if (alu_op[7])  alu_result |= alu_src1 ^ alu_src2;
    if (alu_op[8])  alu_result |= sll_res;
    if (alu_op[9])  alu_result |= srl_res;
    if (alu_op[10]) alu_result |= sra_res;
    if (alu_op[11]) alu_result |= lui_res;
  end
endmodule

module exe_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_NUM     = 12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ds_to_es_valid,
  output logic                  es_allowin,
  input  logic [OP_NUM-1:0]     ds_alu_op,
  input  logic [DATA_WIDTH-1:0] ds_src1,
  input  logic [DATA_WIDTH-1:0] ds_src2,
  input  logic [4:0]            ds_dest,
  input  logic                  ds_gr_we,
  input  logic [DATA_WIDTH-1:0] ds_pc,
  input  logic                  es_flush,
  input  logic                  ms_allowin,
  output logic                  es_to_ms_valid,
  output logic [DATA_WIDTH-1:0] es_result,
  output logic [4:0]            es_dest,
  output logic                  es_gr_we,
  output logic [DATA_WIDTH-1:0] es_pc,
  output logic                  es_fwd_valid
);
  logic                  es_valid;
  logic                  es_ready_go;
  logic [OP_NUM-1:0]     es_alu_op;
  logic [DATA_WIDTH-1:0] es_src1;
  logic [DATA_WIDTH-1:0] es_src2;

  assign es_ready_go    = 1'b1;
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = es_valid && es_ready_go && !es_flush;
  assign es_fwd_valid   = es_valid && es_gr_we && (es_dest != 5'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid  <= 1'b0;
      es_alu_op <= '0;
      es_src1   <= '0;
      es_src2   <= '0;
      es_dest   <= '0;
      es_gr_we  <= 1'b0;
      es_pc     <= '0;
    end else begin
      // Flush wins over a same-cycle accept; a flushed accept leaves the payload untouched.
      if (es_flush) begin
        es_valid <= 1'b0;
      end else if (es_allowin) begin
        es_valid <= ds_to_es_valid;
      end
      if (ds_to_es_valid && es_allowin && !es_flush) begin
        es_alu_op <= ds_alu_op;
        es_src1   <= ds_src1;
        es_src2   <= ds_src2;
        es_dest   <= ds_dest;
        es_gr_we  <= ds_gr_we;
        es_pc     <= ds_pc;
      end
    end
  end

  alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .OP_NUM     (OP_NUM)
  ) u_alu (
    .alu_op     (es_alu_op),
    .alu_src1   (es_src1),
    .alu_src2   (es_src2),
    .alu_result (es_result)
  );
endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 The module SHALL have parameter OP_NUM, default 12, giving the one-hot ALU opcode width.
REQ-003 Port clk  input  1  is the single clock; all state is updated on its rising edge.
REQ-004 Port resetn  input  1  is the asynchronous, active-low reset.
REQ-005 Port ds_to_es_valid  input  1  means the decode stage offers an instruction.
REQ-006 Port es_allowin  output  1  means this stage accepts an instruction this cycle.
REQ-007 Port ds_alu_op  input  OP_NUM  is the one-hot ALU opcode (bit order: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui).
REQ-008 Port ds_src1  input  DATA_WIDTH  is ALU operand 1; for shifts it is the shift amount, using bits [4:0].
REQ-009 Port ds_src2  input  DATA_WIDTH  is ALU operand 2.
REQ-010 Port ds_dest  input  5  is the destination register number.
REQ-011 Port ds_gr_we  input  1  is the register write enable.
REQ-012 Port ds_pc  input  DATA_WIDTH  is the instruction PC.
REQ-013 Port es_flush  input  1  is a synchronous kill of the instruction held in this stage.
REQ-014 Port ms_allowin  input  1  means the memory stage accepts an instruction this cycle.
REQ-015 Port es_to_ms_valid  output  1  means this stage offers an instruction to the memory stage.
REQ-016 Port es_result  output  DATA_WIDTH  is the ALU result of the held instruction.
REQ-017 Ports es_dest (output, 5), es_gr_we (output, 1) and es_pc (output, DATA_WIDTH) carry the held instruction fields.
REQ-018 Port es_fwd_valid  output  1  means the held instruction writes a non-zero register and is valid, for ID-stage bypass.

Function
REQ-019 The stage SHALL hold one instruction, tracked by an es_valid register; es_ready_go is constant 1.
REQ-020 es_allowin SHALL equal !es_valid | ms_allowin.
REQ-021 On a rising edge with ds_to_es_valid & es_allowin, the stage SHALL set es_valid=1 and latch alu_op, src1, src2, dest, gr_we and pc.
REQ-022 On a rising edge with es_allowin & !ds_to_es_valid, the stage SHALL set es_valid=0 and leave the payload registers unchanged.
REQ-023 When es_allowin=0 (stall), all registers SHALL hold and es_result SHALL remain stable.
REQ-024 es_flush=1 at a rising edge SHALL clear es_valid, taking priority over an accept in the same cycle.
REQ-025 es_to_ms_valid SHALL equal es_valid & !es_flush.
REQ-026 es_result SHALL come from an instantiated alu block with OP_NUM=12, driven only by the latched registers; it is valid in the cycle after acceptance (one-cycle latency).
REQ-027 Arithmetic SHALL be modulo 2^DATA_WIDTH. slt/sltu SHALL return 0 or 1 zero-extended. sra SHALL sign-fill. lui SHALL return {src2[15:0],16'b0}.
REQ-028 es_fwd_valid SHALL equal es_valid & es_gr_we & (es_dest!=0).
REQ-029 Back-to-back accepts with ms_allowin=1 SHALL sustain one instruction per cycle without bubbles.

Reset
REQ-030 While resetn=0, es_valid and all payload registers SHALL be 0 immediately, without waiting for a clock edge.
REQ-031 After reset, es_to_ms_valid=0, es_result=0, es_fwd_valid=0, es_allowin=1, es_dest=0 and es_pc=0.
REQ-032 The first edge with resetn=1 and ds_to_es_valid=1 SHALL accept normally.

Verification
REQ-033 Accept add, src1=0x7FFFFFFF, src2=1 -> next cycle es_to_ms_valid=1, es_result=0x80000000.
REQ-034 Accept slt with src1=0xFFFFFFFF, src2=1 -> es_result=1; then sltu with the same operands -> es_result=0.
REQ-035 Accept sra with src1=4, src2=0x80000000, then hold ms_allowin=0 for 3 cycles -> es_result stays 0xF8000000, es_allowin=0, and a new ds_to_es_valid instruction is not accepted until ms_allowin=1.
REQ-036 Assert es_flush coincident with a new accept -> next cycle es_valid=0, es_to_ms_valid=0.
REQ-037 Drop resetn mid-stall with es_valid=1 -> es_to_ms_valid falls to 0 and es_result falls to 0 asynchronously.
REQ-038 Stream of 8 back-to-back instructions (dest 1..8, gr_we=1; dest 0 once) -> 8 consecutive valid outputs; es_fwd_valid=0 for the dest=0 instruction.
